// File: rtl/cpu_pkg.sv
// Shared constants for the load/store path: RV32I funct3 encodings,
// LSU state encoding and the default data width.
package cpu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] LSU_IDLE  = 3'd0;
    localparam logic [2:0] LSU_ADDR  = 3'd1;
    localparam logic [2:0] LSU_DATA  = 3'd2;
    localparam logic [2:0] LSU_WRITE = 3'd3;
    localparam logic [2:0] LSU_RESP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = LSU_IDLE,
        ST_ADDR  = LSU_ADDR,
        ST_DATA  = LSU_DATA,
        ST_WRITE = LSU_WRITE,
        ST_RESP  = LSU_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: load extraction/extension, sub-word store
// merge into a read word, and misalign/illegal detection.
module lsu_lane
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    input  logic            write,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] store_word,
    output logic            bad
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        illegal_s;
    logic        misalign_s;

    assign byte_s = word[{addr, 3'b000} +: 8];
    assign half_s = word[{addr[1], 4'b0000} +: 16];
    assign bad    = illegal_s | misalign_s;

    // Extract the addressed lane and sign- or zero-extend it.
    always_comb begin
        load_val = {XLEN{1'b0}};
        case (funct3)
            F3_B:    load_val = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_H:    load_val = {{(XLEN-16){half_s[15]}}, half_s};
            F3_W:    load_val = word;
            F3_BU:   load_val = {{(XLEN-8){1'b0}}, byte_s};
            F3_HU:   load_val = {{(XLEN-16){1'b0}}, half_s};
            default: load_val = {XLEN{1'b0}};
        endcase
    end

    // Overlay the low byte/half of the store data onto the read word.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B:    store_word[{addr, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

    // Unsigned variants exist only for loads; stores accept b/h/w.
    always_comb begin
        illegal_s  = 1'b1;
        misalign_s = 1'b0;
        case (funct3)
            F3_B: begin
                illegal_s  = 1'b0;
                misalign_s = 1'b0;
            end
            F3_H: begin
                illegal_s  = 1'b0;
                misalign_s = addr[0];
            end
            F3_W: begin
                illegal_s  = 1'b0;
                misalign_s = |addr;
            end
            F3_BU: begin
                illegal_s  = write;
                misalign_s = 1'b0;
            end
            F3_HU: begin
                illegal_s  = write;
                misalign_s = addr[0];
            end
            default: begin
                illegal_s  = 1'b1;
                misalign_s = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts one byte-addressed request at a time into
// word accesses on a synchronous memory, with read-modify-write for sb/sh.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_e        state_r;
    lsu_state_e        state_next_s;
    logic              write_r;
    logic [2:0]        funct3_r;
    logic [1:0]        off_r;
    logic [XLEN-1:0]   wdata_r;
    logic [MEM_AW-1:0] mem_addr_r;
    logic [XLEN-1:0]   mem_wdata_r;
    logic              mem_we_r;
    logic              resp_valid_r;
    logic [XLEN-1:0]   resp_rdata_r;
    logic              resp_err_r;

    logic              accept_s;
    logic              lane_write_s;
    logic [2:0]        lane_f3_s;
    logic [1:0]        lane_off_s;
    logic [XLEN-1:0]   lane_wdata_s;
    logic [XLEN-1:0]   load_val_s;
    logic [XLEN-1:0]   store_word_s;
    logic              bad_s;
    logic [XLEN-1:0]   unused_addr_s;

    // Bits above MEM_AW+1 alias by design.
    assign unused_addr_s = req_addr;

    assign req_ready  = (state_r == ST_IDLE);
    assign accept_s   = req_valid & req_ready;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;

    // The single lane instance checks the live request in IDLE and works on the latched one later.
    always_comb begin
        if (state_r == ST_IDLE) begin
            lane_write_s = req_write;
            lane_f3_s    = req_funct3;
            lane_off_s   = req_addr[1:0];
            lane_wdata_s = req_wdata;
        end else begin
            lane_write_s = write_r;
            lane_f3_s    = funct3_r;
            lane_off_s   = off_r;
            lane_wdata_s = wdata_r;
        end
    end

    lsu_lane #(.XLEN(XLEN)) u_lane (
        .word       (mem_rdata),
        .addr       (lane_off_s),
        .funct3     (lane_f3_s),
        .write      (lane_write_s),
        .wdata      (lane_wdata_s),
        .load_val   (load_val_s),
        .store_word (store_word_s),
        .bad        (bad_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; full-word stores skip the read.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bad_s) begin
                        state_next_s = ST_RESP;
                    end else if (req_write && (req_funct3 == F3_W)) begin
                        state_next_s = ST_WRITE;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR:  state_next_s = ST_DATA;
            ST_DATA: begin
                if (write_r) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_WRITE: state_next_s = ST_RESP;
            ST_RESP:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Request latch, memory-side and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r      <= 1'b0;
            funct3_r     <= 3'b000;
            off_r        <= 2'b00;
            wdata_r      <= {XLEN{1'b0}};
            mem_addr_r   <= {MEM_AW{1'b0}};
            mem_wdata_r  <= {XLEN{1'b0}};
            mem_we_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_err_r   <= 1'b0;
        end else begin
            mem_we_r     <= (state_next_s == ST_WRITE);
            resp_valid_r <= (state_next_s == ST_RESP);
            if (accept_s) begin
                write_r      <= req_write;
                funct3_r     <= req_funct3;
                off_r        <= req_addr[1:0];
                wdata_r      <= req_wdata;
                mem_addr_r   <= req_addr[MEM_AW+1:2];
                resp_rdata_r <= {XLEN{1'b0}};
                resp_err_r   <= bad_s;
                if (req_write && (req_funct3 == F3_W) && !bad_s) begin
                    mem_wdata_r <= req_wdata;
                end
            end else if (state_r == ST_DATA) begin
                if (write_r) begin
                    mem_wdata_r <= store_word_s;
                end else begin
                    resp_rdata_r <= load_val_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests checked against an arithmetic reference model of memory.
module tb_load_store_unit;
    import cpu_pkg::*;

    localparam int MEM_AW = 12;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_we;
    logic [XLEN-1:0]   mem_rdata;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic        mem_init;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_AW(MEM_AW), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h80FF7F01;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Synchronous word memory.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: result, error, latency (cycles from accept to resp) and new memory word.
    task automatic ref_model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic err,
                             output int lat, output logic [31:0] nw);
        int idx, bs, hs, size;
        logic [31:0] old, b, h;
        idx  = int'((a / 32'd4) % 32'(DEPTH));
        old  = ref_mem[idx];
        bs   = 8 * int'(a % 32'd4);
        hs   = 16 * int'((a / 32'd2) % 32'd2);
        b    = (old >> bs) & 32'hFF;
        h    = (old >> hs) & 32'hFFFF;
        size = int'(f3 % 3'd4);
        err  = (w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5))
               || (size == 1 && (a % 32'd2) != 32'd0)
               || (size == 2 && (a % 32'd4) != 32'd0);
        rd  = 32'd0;
        nw  = old;
        lat = 1;
        if (!err) begin
            if (!w) begin
                lat = 3;
                case (f3)
                    3'd0:    rd = (b >= 32'd128)   ? b - 32'd256   : b;
                    3'd1:    rd = (h >= 32'd32768) ? h - 32'd65536 : h;
                    3'd2:    rd = old;
                    3'd4:    rd = b;
                    3'd5:    rd = h;
                    default: rd = 32'd0;
                endcase
            end else if (f3 == 3'd2) begin
                lat = 2;
                nw  = wd;
            end else begin
                lat = 4;
                if (f3 == 3'd0) nw = (old & ~(32'hFF << bs))   | ((wd & 32'hFF) << bs);
                else            nw = (old & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
            end
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rd, exp_word;
        logic        exp_err;
        int          exp_lat, idx, lat, we_cnt;
        ref_model(w, f3, a, wd, exp_rd, exp_err, exp_lat, exp_word);
        idx = int'(a[13:2]);
        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; we_cnt = 0; got = 32'd0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            if (mem_we) begin
                we_cnt++;
                chk("we_addr", {20'd0, mem_addr}, {20'd0, a[13:2]});
                chk("we_data", mem_wdata, exp_word);
            end
            if (resp_valid) begin
                lat = k;
                got = resp_rdata;
                chk("rdata", resp_rdata, exp_rd);
                chk("err", {31'd0, resp_err}, {31'd0, exp_err});
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("we_count", 32'(we_cnt), (w && !exp_err) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        if (w && !exp_err) ref_mem[idx] = exp_word;
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] got, rd_a, rd_b, nw, dummy;
        logic        e_a;
        int          lat_a, lat_b, l_a;
        logic        rw;
        logic [2:0]  rf3;
        logic [31:0] ra, rwd;

        rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;

        // Loads from the 0x80FF7F01 word.
        do_req(1'b0, F3_B,  32'h12, 32'd0, got); chk("tp_lb",  got, 32'hFFFFFFFF);
        do_req(1'b0, F3_BU, 32'h13, 32'd0, got); chk("tp_lbu", got, 32'h00000080);
        do_req(1'b0, F3_H,  32'h12, 32'd0, got); chk("tp_lh",  got, 32'hFFFF80FF);
        do_req(1'b0, F3_HU, 32'h10, 32'd0, got); chk("tp_lhu", got, 32'h00007F01);

        // Sub-word store preserves neighbours; full-word store skips the read.
        do_req(1'b1, F3_B, 32'h11, 32'hAABBCCDD, got);
        chk("tp_sb_mem", mem[4], 32'h80FFDD01);
        do_req(1'b0, F3_W, 32'h10, 32'd0, got); chk("tp_lw", got, 32'h80FFDD01);
        do_req(1'b1, F3_W, 32'h20, 32'hDEADBEEF, got);
        chk("tp_sw_mem", mem[8], 32'hDEADBEEF);

        // Rejected requests.
        do_req(1'b0, F3_H,   32'h13, 32'd0, got);
        do_req(1'b0, F3_W,   32'h22, 32'd0, got);
        do_req(1'b0, 3'b011, 32'h10, 32'd0, got);
        do_req(1'b1, F3_BU,  32'h14, 32'h11223344, got);
        do_req(1'b1, F3_W,   32'h21, 32'h11223344, got);

        do_req(1'b1, F3_H, 32'h12, 32'h55661234, got);
        chk("sh_mem", mem[4], 32'h1234DD01);
        do_req(1'b0, F3_W, 32'h0001_0010, 32'd0, got); chk("alias_lw", got, 32'h1234DD01);

        // Back-to-back with req_valid held high.
        ref_model(1'b0, F3_W,  32'h10, 32'd0, rd_a, e_a, l_a, dummy);
        ref_model(1'b0, F3_BU, 32'h13, 32'd0, rd_b, e_a, l_a, dummy);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
        @(posedge clk);
        #1 req_funct3 = F3_BU; req_addr = 32'h13;
        lat_a = 0; lat_b = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (lat_a == 0) begin
                    lat_a = k; chk("b2b_rd_a", resp_rdata, rd_a);
                end else begin
                    lat_b = k; chk("b2b_rd_b", resp_rdata, rd_b);
                end
            end
            if (k <= 3) chk("b2b_busy", {31'd0, req_ready}, 32'd0);
            if (k == 4) begin
                chk("b2b_idle", {31'd0, req_ready}, 32'd1);
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("b2b_lat_a", 32'(lat_a), 32'd3);
        chk("b2b_lat_b", 32'(lat_b), 32'd7);

        // Reset during DATA of an sh: nothing written, no response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_H; req_addr = 32'h2A; req_wdata = 32'hCAFE9876;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstd_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("rstd_resp", {31'd0, resp_valid}, 32'd0);
            chk("rstd_we", {31'd0, mem_we}, 32'd0);
            @(negedge clk);
        end
        chk("rstd_mem", mem[10], ref_mem[10]);

        // Reset during WRITE of an sb: the write lands, no response.
        ref_model(1'b1, F3_B, 32'h31, 32'h0000005C, rd_a, e_a, l_a, nw);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B; req_addr = 32'h31; req_wdata = 32'h0000005C;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstw_in_write", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_mem[12] = nw;
        chk("rstw_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw_mem", mem[12], nw);
        for (int k = 0; k < 3; k++) begin
            chk("rstw_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end

        // Random requests over a small aliased window.
        for (int n = 0; n < 60; n++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom();
            ra[13:6] = 8'd0;
            rwd = $urandom();
            do_req(rw, rf3, ra, rwd, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute FSM and the word-wide synchronous data memory.
- Takes one load or store request at a time and turns it into word-addressed memory accesses.
- Loads: selects the byte or halfword lane and sign- or zero-extends it.
- Stores: sub-word stores use read-modify-write so neighbouring bytes survive; misaligned and illegal requests are rejected without touching memory.

Parameters:
- MEM_AW, 12, word-address width driven to memory (byte address bits [MEM_AW+1:2] used).
- XLEN, 32, data and byte-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  XLEN  byte address (rs1 + imm).
- req_wdata  in  XLEN  store data (rs2, unmasked).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load result; 0 for stores.
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  XLEN  full word to write.
- mem_we  out  1  write enable, sampled by memory at posedge.
- mem_rdata  in  XLEN  memory read data, valid one edge after mem_addr is sampled.

Behaviour:
- Reset (clk edge with rst=1): state IDLE. Outputs after reset: resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1.
- req_ready = (state==IDLE), combinational from state. A handshake occurs when req_valid && req_ready at a posedge. req_valid while busy is ignored; there is no queue.
- On accept, latch write, funct3, addr[1:0], wdata, and mem_addr = addr[MEM_AW+1:2].
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Legal stores: 000 sb, 001 sh, 010 sw.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Error path: IDLE -> RESP with resp_err=1, rdata=0; no memory access.
- FSM states: IDLE, ADDR, DATA, WRITE, RESP.
- Load path: IDLE -> ADDR (memory samples mem_addr) -> DATA (capture mem_rdata, extract lane, extend, register into resp_rdata) -> RESP -> IDLE.
- Load latency: resp_valid is high in the 3rd cycle after the accept edge, for exactly one cycle.
- Lane selection is little-endian:
  - byte = word[8*addr[1:0] +: 8]
  - half = word[16*addr[1] +: 16]
  - lb/lh sign-extend; lbu/lhu zero-extend.
- sb/sh path: IDLE -> ADDR -> DATA (merge the low byte/half of wdata into the read word at the selected lane, register into mem_wdata) -> WRITE (mem_we=1 for exactly one cycle) -> RESP -> IDLE.
- sw path: IDLE -> WRITE (mem_wdata=wdata, no read) -> RESP -> IDLE.
- mem_we is a registered output, high only in WRITE. mem_addr holds its value from accept until the next accept.
- RESP: resp_valid=1 for one cycle. No backpressure; the core must sample it. A new request may be accepted in the cycle after RESP, when the state is back in IDLE.
- Reset mid-operation: the FSM returns to IDLE and no response is issued.
  - rst asserted while in WRITE: the memory still samples mem_we=1 on that edge, so the write completes.
  - rst in any other state: no write occurs.
- Address wrap: byte-address bits above MEM_AW+1 are ignored; the address aliases modulo 4·2^MEM_AW.

Decomposition:
- Package cpu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the LSU state encoding (3-bit localparams);
  - the XLEN default.
- Sub-module lsu_lane is combinational and is instantiated once.
  - Inputs: word, addr[1:0], funct3, wdata.
  - Outputs: extended load value, merged store word, misalign/illegal flag.
  - The FSM uses the flag at accept and the data outputs in DATA.

Test Plan:
- Memory word at addr 0x10 = 0x80FF7F01; lb 0x12 -> rdata 0xFFFFFFFF; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF80FF; lhu 0x10 -> 0x00007F01; each resp_valid exactly 3 cycles after accept, err=0.
- sb wdata=0xAABBCCDD to 0x11 over word 0x80FF7F01 -> memory word becomes 0x80FFDD01, single mem_we pulse; follow-up lw 0x10 returns 0x80FFDD01.
- sw 0xDEADBEEF to 0x20 -> mem_we high the cycle after accept with mem_addr=8, no read cycle, resp_valid one cycle later.
- lh 0x13, lw 0x22, funct3=011 -> resp_err=1 the cycle after accept, mem_we never asserted, memory unchanged.
- Back-to-back requests with req_valid held high -> req_ready low during ADDR/DATA/WRITE/RESP, second request accepted only in IDLE, responses in order.
- rst asserted during DATA of an sh -> no mem_we pulse, no resp_valid, req_ready=1 the next cycle; rst during WRITE -> the write lands, no response.
